// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two small result FIFOs (ALU, LSB) drained round-robin
// into a registered broadcast port, with mispredict flush and global stall.
module cdb_arbiter #(
    parameter int unsigned ROB_ID_W   = 4,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned PTR_W      = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_rdy,
    input  logic                i_clear,
    input  logic                i_alu_valid,
    output logic                o_alu_ready,
    input  logic [ROB_ID_W-1:0] i_alu_rob_id,
    input  logic [31:0]         i_alu_value,
    input  logic                i_lsb_valid,
    output logic                o_lsb_ready,
    input  logic [ROB_ID_W-1:0] i_lsb_rob_id,
    input  logic [31:0]         i_lsb_value,
    output logic                o_cdb_valid,
    output logic [ROB_ID_W-1:0] o_cdb_rob_id,
    output logic [31:0]         o_cdb_value,
    output logic                o_cdb_src
);
    localparam int unsigned EW = ROB_ID_W + 32;
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [EW-1:0]       r_alu_mem [FIFO_DEPTH];
    logic [EW-1:0]       r_lsb_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_alu_wr, r_alu_rd, r_lsb_wr, r_lsb_rd;
    logic [PTR_W:0]      r_alu_cnt, r_lsb_cnt;
    logic                r_rr_last;
    logic                r_cdb_valid;
    logic [ROB_ID_W-1:0] r_cdb_rob_id;
    logic [31:0]         r_cdb_value;
    logic                r_cdb_src;

    logic          w_active, w_alu_ne, w_lsb_ne, w_gnt_alu, w_gnt_lsb;
    logic          w_alu_push, w_lsb_push, w_alu_pop, w_lsb_pop;
    logic [EW-1:0] w_head;

    // Readiness looks only at registered counts, never at this cycle's dequeue.
    assign w_active    = i_rdy && !i_clear;
    assign o_alu_ready = !i_rst && w_active && (r_alu_cnt != CNT_FULL);
    assign o_lsb_ready = !i_rst && w_active && (r_lsb_cnt != CNT_FULL);
    assign w_alu_push  = i_alu_valid && o_alu_ready;
    assign w_lsb_push  = i_lsb_valid && o_lsb_ready;

    assign w_alu_ne  = (r_alu_cnt != '0);
    assign w_lsb_ne  = (r_lsb_cnt != '0);
    assign w_gnt_alu = w_alu_ne && (!w_lsb_ne || r_rr_last);
    assign w_gnt_lsb = w_lsb_ne && (!w_alu_ne || !r_rr_last);
    assign w_alu_pop = w_active && w_gnt_alu;
    assign w_lsb_pop = w_active && w_gnt_lsb;
    assign w_head    = w_gnt_lsb ? r_lsb_mem[r_lsb_rd] : r_alu_mem[r_alu_rd];

    always_ff @(posedge i_clk) begin
        if (w_alu_push) r_alu_mem[r_alu_wr] <= {i_alu_rob_id, i_alu_value};
        if (w_lsb_push) r_lsb_mem[r_lsb_wr] <= {i_lsb_rob_id, i_lsb_value};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_alu_wr     <= '0;
            r_alu_rd     <= '0;
            r_alu_cnt    <= '0;
            r_lsb_wr     <= '0;
            r_lsb_rd     <= '0;
            r_lsb_cnt    <= '0;
            r_rr_last    <= 1'b1;
            r_cdb_valid  <= 1'b0;
            r_cdb_rob_id <= '0;
            r_cdb_value  <= '0;
            r_cdb_src    <= 1'b0;
        end else if (i_rdy) begin
            if (i_clear) begin
                r_alu_wr    <= '0;
                r_alu_rd    <= '0;
                r_alu_cnt   <= '0;
                r_lsb_wr    <= '0;
                r_lsb_rd    <= '0;
                r_lsb_cnt   <= '0;
                r_rr_last   <= 1'b1;
                r_cdb_valid <= 1'b0;
            end else begin
                if (w_alu_push) r_alu_wr <= r_alu_wr + PTR_ONE;
                if (w_alu_pop)  r_alu_rd <= r_alu_rd + PTR_ONE;
                if (w_alu_push && !w_alu_pop)      r_alu_cnt <= r_alu_cnt + CNT_ONE;
                else if (!w_alu_push && w_alu_pop) r_alu_cnt <= r_alu_cnt - CNT_ONE;

                if (w_lsb_push) r_lsb_wr <= r_lsb_wr + PTR_ONE;
                if (w_lsb_pop)  r_lsb_rd <= r_lsb_rd + PTR_ONE;
                if (w_lsb_push && !w_lsb_pop)      r_lsb_cnt <= r_lsb_cnt + CNT_ONE;
                else if (!w_lsb_push && w_lsb_pop) r_lsb_cnt <= r_lsb_cnt - CNT_ONE;

                if (w_alu_pop || w_lsb_pop) begin
                    r_rr_last    <= w_gnt_lsb;
                    r_cdb_valid  <= 1'b1;
                    r_cdb_rob_id <= w_head[EW-1:32];
                    r_cdb_value  <= w_head[31:0];
                    r_cdb_src    <= w_gnt_lsb;
                end else begin
                    r_cdb_valid <= 1'b0;
                end
            end
        end
    end

    assign o_cdb_valid  = r_cdb_valid;
    assign o_cdb_rob_id = r_cdb_rob_id;
    assign o_cdb_value  = r_cdb_value;
    assign o_cdb_src    = r_cdb_src;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a vector table stepped one clock per row,
// plus a hand-written asynchronous-reset sequence.
module tb_cdb_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rdy = 1'b1;
    logic       clear = 1'b0;
    logic       alu_valid = 1'b0, lsb_valid = 1'b0;
    logic [3:0] alu_rob_id = '0, lsb_rob_id = '0;
    logic [31:0] alu_value = '0, lsb_value = '0;
    logic       alu_ready, lsb_ready;
    logic       cdb_valid, cdb_src;
    logic [3:0] cdb_rob_id;
    logic [31:0] cdb_value;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cdb_arbiter #(.ROB_ID_W(4), .FIFO_DEPTH(2), .PTR_W(1)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rdy       (rdy),
        .i_clear     (clear),
        .i_alu_valid (alu_valid),
        .o_alu_ready (alu_ready),
        .i_alu_rob_id(alu_rob_id),
        .i_alu_value (alu_value),
        .i_lsb_valid (lsb_valid),
        .o_lsb_ready (lsb_ready),
        .i_lsb_rob_id(lsb_rob_id),
        .i_lsb_value (lsb_value),
        .o_cdb_valid (cdb_valid),
        .o_cdb_rob_id(cdb_rob_id),
        .o_cdb_value (cdb_value),
        .o_cdb_src   (cdb_src)
    );

    typedef struct {
        logic        rst, rdy, clr;
        logic        av;
        logic [3:0]  aid;
        logic [31:0] aval;
        logic        lv;
        logic [3:0]  lid;
        logic [31:0] lval;
        logic        ear, elr, ecv;
        logic [3:0]  eid;
        logic [31:0] eval;
        logic        esrc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic y, input logic c,
                       input logic av, input logic [3:0] aid, input logic [31:0] aval,
                       input logic lv, input logic [3:0] lid, input logic [31:0] lval,
                       input logic ear, input logic elr, input logic ecv,
                       input logic [3:0] eid, input logic [31:0] eval, input logic esrc);
        vec_t v;
        v.rst = r; v.rdy = y; v.clr = c;
        v.av = av; v.aid = aid; v.aval = aval;
        v.lv = lv; v.lid = lid; v.lval = lval;
        v.ear = ear; v.elr = elr; v.ecv = ecv; v.eid = eid; v.eval = eval; v.esrc = esrc;
        tbl.push_back(v);
    endtask

    // Shorthand for rows with no producer activity.
    task automatic idle(input logic ear, input logic elr, input logic ecv,
                        input logic [3:0] eid, input logic [31:0] eval, input logic esrc);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, ear, elr, ecv, eid, eval, esrc);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic chk_outs(input int row, input logic ear, input logic elr, input logic ecv,
                            input logic [3:0] eid, input logic [31:0] eval, input logic esrc);
        chk("alu_ready", row, 32'(alu_ready), 32'(ear));
        chk("lsb_ready", row, 32'(lsb_ready), 32'(elr));
        chk("cdb_valid", row, 32'(cdb_valid), 32'(ecv));
        chk("cdb_rob_id", row, 32'(cdb_rob_id), 32'(eid));
        chk("cdb_value", row, cdb_value, eval);
        chk("cdb_src", row, 32'(cdb_src), 32'(esrc));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Each row: inputs applied, outputs checked before the next edge.
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // ALU only: two-cycle latency, single-cycle pulse
        add(0, 1, 0, 1, 3, 'hAA, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        idle(1, 1, 0, 0, 0, 0);
        idle(1, 1, 1, 3, 'hAA, 0);
        idle(1, 1, 0, 3, 'hAA, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Contention: ALU first, then LSB; repeat pair favours ALU again
        add(0, 1, 0, 1, 1, 'h11, 1, 2, 'h22, 1, 1, 0, 0, 0, 0);
        idle(1, 1, 0, 0, 0, 0);
        idle(1, 1, 1, 1, 'h11, 0);
        add(0, 1, 0, 1, 10, 'h33, 1, 11, 'h44, 1, 1, 1, 2, 'h22, 1);
        idle(1, 1, 0, 2, 'h22, 1);
        idle(1, 1, 1, 10, 'h33, 0);
        idle(1, 1, 1, 11, 'h44, 1);
        idle(1, 1, 0, 11, 'h44, 1);
        // Backpressure: ALU 4..7 held until accepted, LSB keeps the bus busy
        add(0, 1, 0, 1, 4, 'h44, 1, 12, 'h5C, 1, 1, 0, 11, 'h44, 1);
        add(0, 1, 0, 1, 5, 'h45, 1, 13, 'h5D, 1, 1, 0, 11, 'h44, 1);
        add(0, 1, 0, 1, 6, 'h46, 1, 14, 'h5E, 1, 0, 1, 4, 'h44, 0);
        add(0, 1, 0, 1, 7, 'h47, 1, 14, 'h5E, 0, 1, 1, 12, 'h5C, 1);
        add(0, 1, 0, 1, 7, 'h47, 1, 15, 'h5F, 1, 0, 1, 5, 'h45, 0);
        add(0, 1, 0, 0, 0, 0, 1, 15, 'h5F, 0, 1, 1, 13, 'h5D, 1);
        idle(1, 0, 1, 6, 'h46, 0);
        idle(1, 1, 1, 14, 'h5E, 1);
        idle(1, 1, 1, 7, 'h47, 0);
        idle(1, 1, 1, 15, 'h5F, 1);
        idle(1, 1, 0, 15, 'h5F, 1);
        // Flush: ALU holds 8,9 and LSB holds 17 when clear hits
        add(0, 1, 0, 1, 2, 'h22, 0, 0, 0, 1, 1, 0, 15, 'h5F, 1);
        add(0, 1, 0, 1, 8, 'h88, 1, 16, 'h66, 1, 1, 0, 15, 'h5F, 1);
        add(0, 1, 0, 1, 9, 'h99, 1, 17, 'h77, 1, 1, 1, 2, 'h22, 0);
        add(0, 1, 1, 1, 12, 'hCC, 1, 13, 'hDD, 0, 0, 1, 16, 'h66, 1);
        idle(1, 1, 0, 16, 'h66, 1);
        idle(1, 1, 0, 16, 'h66, 1);
        // rdy stall with id 5 on the bus and id 6 waiting in LSB
        add(0, 1, 0, 1, 5, 'h55, 1, 6, 'h66, 1, 1, 0, 16, 'h66, 1);
        idle(1, 1, 0, 16, 'h66, 1);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 1, 1, 'h01, 1, 1, 'h01, 0, 0, 1, 5, 'h55, 0);
        idle(1, 1, 1, 5, 'h55, 0);
        idle(1, 1, 1, 6, 'h66, 1);
        idle(1, 1, 0, 6, 'h66, 1);

        repeat (2) @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            rst = tbl[i].rst; rdy = tbl[i].rdy; clear = tbl[i].clr;
            alu_valid = tbl[i].av; alu_rob_id = tbl[i].aid; alu_value = tbl[i].aval;
            lsb_valid = tbl[i].lv; lsb_rob_id = tbl[i].lid; lsb_value = tbl[i].lval;
            #1;
            chk_outs(i, tbl[i].ear, tbl[i].elr, tbl[i].ecv, tbl[i].eid, tbl[i].eval,
                     tbl[i].esrc);
            tick();
        end

        // Asynchronous reset between edges while both FIFOs hold entries
        rst = 1'b0; rdy = 1'b1; clear = 1'b0;
        for (int k = 0; k < 4; k++) begin
            alu_valid = 1'b1; alu_rob_id = 4'(k); alu_value = 32'hA0 + 32'(k);
            lsb_valid = 1'b1; lsb_rob_id = 4'(8 + k); lsb_value = 32'hB0 + 32'(k);
            tick();
        end
        chk("pre_reset_valid", 100, 32'(cdb_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_outs(101, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
        alu_valid = 1'b0; lsb_valid = 1'b0;
        tick();
        rst = 1'b0;
        alu_valid = 1'b1; alu_rob_id = 4'd9; alu_value = 32'h1234_5678;
        #1;
        chk("post_reset_alu_ready", 102, 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        chk("lat_edge1_valid", 103, 32'(cdb_valid), 32'd0);
        tick();
        chk_outs(104, 1'b1, 1'b1, 1'b1, 4'd9, 32'h1234_5678, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("no_stale_valid", 105 + k, 32'(cdb_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates one shared result broadcast bus (CDB) between two producers: the RS/ALU result port and the LSB load result port.
- Each producer writes into its own small FIFO. A round-robin arbiter drains one entry per cycle into a registered CDB.
- The registered CDB output drives the RoB result inputs and the RS/LSB operand-wakeup listeners.
- A mispredict `clear` flushes all in-flight results.

Parameters:
- ROB_ID_W, 4, width of a RoB entry index; matches the `ROB_SIZE_WIDTH` config value.
- FIFO_DEPTH, 2, entries per source FIFO; power of two, at least 2.
- PTR_W, 1, log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global enable; when low, all state holds
- clear  in  1  mispredict flush from RoB, synchronous, qualified by rdy
- alu_valid  in  1  RS/ALU result offered
- alu_ready  out  1  ALU FIFO can accept
- alu_rob_id  in  ROB_ID_W  destination RoB entry of ALU result
- alu_value  in  32  ALU result
- lsb_valid  in  1  LSB result offered
- lsb_ready  out  1  LSB FIFO can accept
- lsb_rob_id  in  ROB_ID_W  destination RoB entry of LSB result
- lsb_value  in  32  LSB result
- cdb_valid  out  1  broadcast valid, registered
- cdb_rob_id  out  ROB_ID_W  broadcast RoB index, registered
- cdb_value  out  32  broadcast value, registered
- cdb_src  out  1  source of current broadcast: 0 = ALU, 1 = LSB, registered

Behaviour:

Reset:
- rst is asynchronous and active-high.
- While rst is high, both FIFOs are emptied (rd/wr pointers and counts = 0) and rr_last = 1, so the ALU is favoured first.
- Registered outputs reset to: cdb_valid 0, cdb_rob_id 0, cdb_value 0, cdb_src 0.
- alu_ready and lsb_ready are 0 while rst is high.

Ready:
- x_ready = rdy && !clear && (count_x != FIFO_DEPTH).
- x_ready depends only on registered count, never on the same-cycle dequeue (no combinational path from valid to ready).
- Enqueue at a posedge when x_valid && x_ready; {rob_id, value} is written at wr_ptr, wr_ptr wraps modulo FIFO_DEPTH, count increments.

Arbitration (combinational on FIFO heads, evaluated when rdy && !clear):
- Only ALU FIFO non-empty: grant ALU.
- Only LSB FIFO non-empty: grant LSB.
- Both non-empty: grant the source not equal to rr_last; then rr_last <= granted source.
- Neither non-empty: no grant; rr_last holds.
- Granted head is dequeued at the posedge (rd_ptr wraps, count decrements). The same edge loads cdb_* with {1, head rob_id, head value, source}.
- No grant: cdb_valid <= 0; cdb_rob_id, cdb_value and cdb_src hold.
- Enqueue and dequeue on the same FIFO in the same cycle: count unchanged, both pointers advance.

Latency and throughput:
- Uncontested result accepted at edge N is on the CDB for exactly one cycle after edge N+1 (two-cycle latency).
- Sustained throughput is one broadcast per cycle total.
- Under continuous contention, the sources alternate strictly.

rdy low:
- All FIFO, pointer, rr_last and cdb_* registers hold, including cdb_valid.
- Both ready outputs are 0.

clear (rdy high):
- Takes priority over enqueue and dequeue.
- At the edge: both FIFOs are emptied, cdb_valid <= 0, rr_last <= 1; no grant is issued that cycle.
- Inputs presented during a clear cycle are dropped.

Ordering:
- Results from one source are broadcast in acceptance order.
- No ordering is guaranteed between the two sources.

Test Plan:
1. ALU-only: reset, then alu_valid with rob_id 3, value 0x0000_00AA accepted at edge 1 -> cdb_valid=1, rob_id=3, value=0xAA, src=0 during the cycle after edge 2; cdb_valid=0 the following cycle.
2. Contention: ALU rob_id 1/value 0x11 and LSB rob_id 2/value 0x22 accepted at the same edge -> CDB shows ALU (id 1) then LSB (id 2) on consecutive cycles. A repeat pair then shows ALU first again, because rr_last=1 after the LSB grant.
3. Backpressure: hold alu_valid high with ids 4, 5, 6, 7 while lsb keeps the bus contended -> alu_ready drops after the FIFO holds 2 entries. All four ids appear on the CDB in order 4, 5, 6, 7, with none lost or duplicated.
4. Flush: load ALU FIFO with ids 8 and 9, assert clear for one rdy cycle -> cdb_valid=0 next cycle, ids 8 and 9 never broadcast, both ready outputs 0 during the clear cycle.
5. rdy stall: with cdb_valid=1 (id 5) and LSB FIFO holding id 6, drop rdy for 3 cycles -> cdb holds id 5 valid, no dequeue, readies 0. After rdy returns, id 6 is broadcast next.
6. Async reset mid-operation: assert rst between clock edges with both FIFOs full -> cdb_valid and readies drop to 0 immediately. After release, the first new ALU request broadcasts with 2-cycle latency and no stale entries appear.
